// File: rtl/patmos_uart_pkg.sv
// Shared Patmos UART definitions: byte width, TX arbiter state encodings and defaults.
package patmos_uart_pkg;

  localparam int UART_DW             = 8;
  localparam int ARB_DEFAULT_TIMEOUT = 4096;

  typedef enum logic {
    ARB_ST_IDLE   = 1'b0,
    ARB_ST_LOCKED = 1'b1
  } arb_state_e;

  // Circular successor of a requester index; the pointer restarts just past the releasing owner.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request bit at or after
// the pointer, searching circularly. Shared by Patmos arbiters.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (!o_found && i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX core between NUM_REQ byte streams; a grant stays locked for a
// whole message (until a last byte is accepted) or until the owner idles past TIMEOUT.
module uart_tx_arbiter
  import patmos_uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = UART_DW,
  parameter int TIMEOUT    = ARB_DEFAULT_TIMEOUT
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_tx_valid,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  input  logic                          i_tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_busy,
  output logic                          o_timeout_evt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      w_rr_ptr_nxt;
  logic [IDX_W-1:0]      r_grant_id;
  logic [IDX_W-1:0]      w_grant_nxt;
  logic [CNT_W-1:0]      r_idle_cnt;
  logic [CNT_W-1:0]      w_idle_nxt;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_pick_found;
  logic [IDX_W-1:0]      w_release_ptr;
  logic                  w_own_valid;
  logic                  w_own_last;
  logic [DATA_WIDTH-1:0] w_req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_req_bytes[g] = i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_own_valid   = i_req_valid[r_grant_id];
  assign w_own_last    = i_req_last[r_grant_id];
  assign w_release_ptr = IDX_W'(rr_next(int'(r_grant_id), NUM_REQ));
  assign o_tx_data     = w_req_bytes[r_grant_id];
  assign o_grant_id    = r_grant_id;

  // Only the owner is ever visible to the UART; everyone else is stalled until release.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_grant_nxt   = r_grant_id;
    w_idle_nxt    = r_idle_cnt;
    o_tx_valid    = 1'b0;
    o_req_ready   = '0;
    o_busy        = 1'b0;
    o_timeout_evt = 1'b0;
    case (r_state)
      ARB_ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = ARB_ST_LOCKED;
          w_grant_nxt = w_pick_idx;
          w_idle_nxt  = '0;
        end
      end
      ARB_ST_LOCKED: begin
        o_busy                  = 1'b1;
        o_tx_valid              = w_own_valid;
        o_req_ready[r_grant_id] = i_tx_ready;
        if (w_own_valid) begin
          w_idle_nxt = '0;
          if (i_tx_ready && w_own_last) begin
            w_state_nxt  = ARB_ST_IDLE;
            w_rr_ptr_nxt = w_release_ptr;
          end
        end else if (r_idle_cnt == CNT_MAX) begin
          o_timeout_evt = 1'b1;
          w_state_nxt   = ARB_ST_IDLE;
          w_rr_ptr_nxt  = w_release_ptr;
          w_idle_nxt    = '0;
        end else begin
          w_idle_nxt = r_idle_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ARB_ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ARB_ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_id <= w_grant_nxt;
      r_idle_cnt <= w_idle_nxt;
    end
  end

endmodule
